// File: rtl/voxel_pixel_shader.sv
// Per-pixel voxel ray-marcher: keeps the nearest hit (id, depth) per frame and shades from the palette.
// Build option: define PIXEL_SHADER_EARLY_EXIT_EN to abort a march once no nearer hit is possible.
module voxel_pixel_shader #(
  parameter int ROW_BITS     = 8,
  parameter int COL_BITS     = 8,
  parameter int COORD_BITS   = 8,
  parameter int PALETTE_BITS = 8,
  parameter int FRACT_BITS   = 8,
  parameter int PIXEL_BITS   = 8,
  parameter int MAX_STEPS    = 1024,
  parameter int STEP_SHIFT   = 4
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  do_rasterize,
  input  logic                                  do_shade,
  input  logic [COORD_BITS-1:0]                 voxel_x,
  input  logic [COORD_BITS-1:0]                 voxel_y,
  input  logic [COORD_BITS-1:0]                 voxel_z,
  input  logic [PALETTE_BITS-1:0]               voxel_id,
  input  logic [PIXEL_BITS-1:0]                 palette_entry,
  input  logic signed [COORD_BITS+FRACT_BITS-1:0] cam_pos_x,
  input  logic signed [COORD_BITS+FRACT_BITS-1:0] cam_pos_y,
  input  logic signed [COORD_BITS+FRACT_BITS-1:0] cam_pos_z,
  input  logic signed [COORD_BITS+FRACT_BITS-1:0] cam_look_x,
  input  logic signed [COORD_BITS+FRACT_BITS-1:0] cam_look_y,
  input  logic signed [COORD_BITS+FRACT_BITS-1:0] cam_look_z,
  input  logic [ROW_BITS-1:0]                   row,
  input  logic [COL_BITS-1:0]                   col,
  output logic                                  rasterizing_done,
  output logic                                  shading_done,
  output logic [PIXEL_BITS-1:0]                 pixel
);

  localparam int D  = $clog2(MAX_STEPS);
  localparam int CW = COORD_BITS + FRACT_BITS;
  localparam int PW = CW + 2;
  localparam int SW = FRACT_BITS + 2;
  localparam int MW = CW + SW + 2;

  typedef enum logic [1:0] {IDLE, MARCH, RDONE, SDONE} state_e;

  state_e state_q, state_d;

  logic signed [PW-1:0]   p_q [3];
  logic signed [PW-1:0]   p_d [3];
  logic signed [PW-1:0]   step_q [3];
  logic signed [PW-1:0]   step_d [3];
  logic [COORD_BITS-1:0]  vox_q [3];
  logic [COORD_BITS-1:0]  vox_d [3];
  logic [PALETTE_BITS-1:0] vid_q, vid_d;
  logic [D-1:0]           k_q, k_d;
  logic [D-1:0]           depth_q, depth_d;
  logic [PALETTE_BITS-1:0] id_q, id_d;
  logic [PIXEL_BITS-1:0]  pixel_q, pixel_d;
  logic                   frame_q, frame_d;

  // Screen offsets as signed fractions: (idx - 2^(N-1)) / 2^N in units of 2^-FRACT_BITS.
  logic signed [COL_BITS:0] col_c;
  logic signed [ROW_BITS:0] row_c;
  logic signed [MW-1:0]     s_wide, t_wide, sx_prod, sz_prod;
  logic signed [SW-1:0]     s_frac, t_frac;
  logic signed [PW-1:0]     dir [3];

  assign col_c  = $signed({1'b0, col}) - $signed({2'b01, {(COL_BITS-1){1'b0}}});
  assign row_c  = $signed({1'b0, row}) - $signed({2'b01, {(ROW_BITS-1){1'b0}}});
  assign s_wide = (MW'(col_c) <<< FRACT_BITS) >>> COL_BITS;
  assign t_wide = (MW'(row_c) <<< FRACT_BITS) >>> ROW_BITS;
  assign s_frac = SW'(s_wide);
  assign t_frac = SW'(t_wide);

  // right = (-look_z, 0, look_x); negate before the floor so rounding is toward -inf on s*right.
  always_comb begin
    sx_prod = (MW'(s_frac) * (-MW'(cam_look_z))) >>> FRACT_BITS;
    sz_prod = (MW'(s_frac) * MW'(cam_look_x)) >>> FRACT_BITS;
    dir[0]  = PW'(cam_look_x) + PW'(sx_prod);
    dir[1]  = PW'(cam_look_y) - PW'(t_frac);
    dir[2]  = PW'(cam_look_z) + PW'(sz_prod);
  end

  logic hit, last_step, early_abort;

  always_comb begin
    hit = 1'b1;
    for (int a = 0; a < 3; a++) begin
      if (p_q[a][PW-1] || (p_q[a][PW-1:FRACT_BITS] != {2'b00, vox_q[a]})) hit = 1'b0;
    end
  end

  assign last_step = (k_q == D'(MAX_STEPS - 1));

`ifdef PIXEL_SHADER_EARLY_EXIT_EN
  assign early_abort = (k_q >= depth_q);
`else
  assign early_abort = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (do_rasterize)  state_d = MARCH;
        else if (do_shade) state_d = SDONE;
      end
      MARCH: begin
        if (early_abort || hit || last_step) state_d = RDONE;
      end
      RDONE:   state_d = IDLE;
      SDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rasterizing_done = (state_q == RDONE);
    shading_done     = (state_q == SDONE);
  end

  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      p_d[a]    = p_q[a];
      step_d[a] = step_q[a];
      vox_d[a]  = vox_q[a];
    end
    vid_d   = vid_q;
    k_d     = k_q;
    depth_d = depth_q;
    id_d    = id_q;
    pixel_d = pixel_q;
    frame_d = frame_q;

    case (state_q)
      IDLE: begin
        if (do_rasterize) begin
          if (!frame_q) begin
            depth_d = '1;
            id_d    = '0;
          end
          frame_d  = 1'b1;
          vox_d[0] = voxel_x;
          vox_d[1] = voxel_y;
          vox_d[2] = voxel_z;
          vid_d    = voxel_id;
          p_d[0]   = PW'(cam_pos_x);
          p_d[1]   = PW'(cam_pos_y);
          p_d[2]   = PW'(cam_pos_z);
          for (int a = 0; a < 3; a++) step_d[a] = dir[a] >>> STEP_SHIFT;
          k_d      = '0;
        end else begin
          frame_d = 1'b0;
          if (do_shade && (id_q != '0) && (voxel_id == id_q)) pixel_d = palette_entry;
        end
      end
      MARCH: begin
        if (!early_abort) begin
          if (hit) begin
            // Strict compare: an equal-depth later voxel does not displace the earlier one.
            if (k_q < depth_q) begin
              depth_d = k_q;
              id_d    = vid_q;
            end
          end else begin
            for (int a = 0; a < 3; a++) p_d[a] = p_q[a] + step_q[a];
            k_d = k_q + D'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      depth_q <= '1;
      id_q    <= '0;
      pixel_q <= '0;
      frame_q <= 1'b0;
    end else begin
      depth_q <= depth_d;
      id_q    <= id_d;
      pixel_q <= pixel_d;
      frame_q <= frame_d;
    end
  end

  // NOTE: march working registers are always loaded on acceptance before use, so they carry no reset.
  always_ff @(posedge clock) begin
    for (int a = 0; a < 3; a++) begin
      p_q[a]    <= p_d[a];
      step_q[a] <= step_d[a];
      vox_q[a]  <= vox_d[a];
    end
    vid_q <= vid_d;
    k_q   <= k_d;
  end

  assign pixel = pixel_q;

endmodule

// File: tb/tb_voxel_pixel_shader.sv
// Directed bench for voxel_pixel_shader: camera (4,4,4) looking (-1,-1,-1), centre pixel.
// Expected latencies follow PIXEL_SHADER_EARLY_EXIT_EN when the bundle is built with it.
module tb_voxel_pixel_shader;

  logic               clock = 1'b0;
  logic               reset;
  logic               do_rasterize, do_shade;
  logic [7:0]         voxel_x, voxel_y, voxel_z, voxel_id, palette_entry;
  logic signed [15:0] cam_pos_x, cam_pos_y, cam_pos_z;
  logic signed [15:0] cam_look_x, cam_look_y, cam_look_z;
  logic [7:0]         row, col;
  logic               rasterizing_done, shading_done;
  logic [7:0]         pixel;

  int checks   = 0;
  int failures = 0;

`ifdef PIXEL_SHADER_EARLY_EXIT_EN
  localparam int LAT_FAR_AFTER_NEAR = 19;
  localparam int LAT_MISS           = 19;
`else
  localparam int LAT_FAR_AFTER_NEAR = 51;
  localparam int LAT_MISS           = 1025;
`endif

  always #5 clock = ~clock;

  voxel_pixel_shader dut (
    .clock            (clock),
    .reset            (reset),
    .do_rasterize     (do_rasterize),
    .do_shade         (do_shade),
    .voxel_x          (voxel_x),
    .voxel_y          (voxel_y),
    .voxel_z          (voxel_z),
    .voxel_id         (voxel_id),
    .palette_entry    (palette_entry),
    .cam_pos_x        (cam_pos_x),
    .cam_pos_y        (cam_pos_y),
    .cam_pos_z        (cam_pos_z),
    .cam_look_x       (cam_look_x),
    .cam_look_y       (cam_look_y),
    .cam_look_z       (cam_look_z),
    .row              (row),
    .col              (col),
    .rasterizing_done (rasterizing_done),
    .shading_done     (shading_done),
    .pixel            (pixel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after the pulse.
  task automatic rast(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                      input logic [7:0] id, input int exp_lat, input string tag);
    int lat;
    bit sd;
    voxel_x = x; voxel_y = y; voxel_z = z; voxel_id = id;
    do_rasterize = 1'b1;
    @(posedge clock);
    lat = 0;
    sd  = 1'b0;
    for (int i = 1; i <= 1100; i++) begin
      @(negedge clock);
      if (shading_done) sd = 1'b1;
      if (rasterizing_done) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " no shading_done"}, 32'(sd), 0);
    @(negedge clock);
    check({tag, " done is one cycle"}, 32'(rasterizing_done), 0);
  endtask

  task automatic shade(input logic [7:0] id, input logic [7:0] pal, input logic [7:0] exp_pix,
                       input string tag);
    voxel_id = id; palette_entry = pal; do_shade = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check({tag, " shading_done"}, 32'(shading_done), 1);
    check({tag, " pixel"}, 32'(pixel), 32'(exp_pix));
    do_shade = 1'b0;
    @(negedge clock);
    check({tag, " done is one cycle"}, 32'(shading_done), 0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    do_rasterize = 1'b0; do_shade = 1'b0;
    voxel_x = 8'd0; voxel_y = 8'd0; voxel_z = 8'd0; voxel_id = 8'd0; palette_entry = 8'd0;
    cam_pos_x  = 16'sd1024;  cam_pos_y  = 16'sd1024;  cam_pos_z  = 16'sd1024;
    cam_look_x = -16'sd256;  cam_look_y = -16'sd256;  cam_look_z = -16'sd256;
    row = 8'd128; col = 8'd128;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset pixel", 32'(pixel), 0);
    check("reset rasterizing_done", 32'(rasterizing_done), 0);
    check("reset shading_done", 32'(shading_done), 0);
    reset = 1'b0;
    @(negedge clock);

    shade(8'd0, 8'h55, 8'h00, "shade id0 empty");

    // One frame: do_rasterize stays high across the stream.
    rast(8'd0,   8'd0, 8'd0, 8'd1, 51,                 "rast v000 id1");
    rast(8'd2,   8'd2, 8'd2, 8'd2, 19,                 "rast v222 id2");
    rast(8'd0,   8'd0, 8'd0, 8'd1, LAT_FAR_AFTER_NEAR, "rast v000 id1 again");
    rast(8'd200, 8'd0, 8'd0, 8'd3, LAT_MISS,           "rast miss id3");
    rast(8'd2,   8'd2, 8'd2, 8'd4, 19,                 "rast tie id4");
    do_rasterize = 1'b0;

    shade(8'd1, 8'h11, 8'h00, "shade id1 not nearest");
    shade(8'd2, 8'h22, 8'h22, "shade id2 nearest");
    shade(8'd4, 8'h44, 8'h22, "shade id4 tie loser");
    shade(8'd3, 8'h33, 8'h22, "shade id3 miss");

    // New frame with do_shade also high: rasterize wins.
    do_shade = 1'b1;
    rast(8'd0, 8'd0, 8'd0, 8'd1, 51, "new frame v000 both high");
    do_rasterize = 1'b0;
    do_shade = 1'b0;
    shade(8'd2, 8'h22, 8'h22, "new frame shade stale id2");
    shade(8'd1, 8'h11, 8'h11, "new frame shade id1");

    // Reset in the middle of a march.
    voxel_x = 8'd2; voxel_y = 8'd2; voxel_z = 8'd2; voxel_id = 8'd2;
    do_rasterize = 1'b1;
    @(posedge clock);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    do_rasterize = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("mid-march reset rasterizing_done", 32'(rasterizing_done), 0);
    check("mid-march reset shading_done", 32'(shading_done), 0);
    check("mid-march reset pixel", 32'(pixel), 0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clock);
      if (rasterizing_done) seen = 1'b1;
    end
    check("aborted march gives no done", 32'(seen), 0);
    shade(8'd2, 8'h22, 8'h00, "post reset shade id2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
